// File: rtl/mem_sched_pkg.sv
// Shared definitions for the cellram port scheduler.
//   - Direction constants for grant_dir.
//   - Scheduler FSM state encoding.
//   - even_clamp_len(): clamps a byte count to a burst maximum and rounds it down to even.
package mem_sched_pkg;

    localparam logic READING = 1'b0;  // RAM to FIFO
    localparam logic WRITING = 1'b1;  // FIFO to RAM

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2,
        BUSY  = 2'd3
    } state_t;

    // The datapath moves 16-bit words, so every burst length is forced even.
    function automatic logic [31:0] even_clamp_len(input logic [31:0] level,
                                                   input logic [31:0] max_burst);
        logic [31:0] len;
        len = (level > max_burst) ? max_burst : level;
        return {len[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_port_scheduler_slot_eval.sv
// slot_eval: combinational view of one scheduler slot.
//   slot          in   slot index (0..NUM_PORTS-1 write ports, then read ports)
//   write_levels  in   packed per-port write FIFO levels
//   read_pending  in   packed per-port read pending byte counts
//   eligible      out  slot has at least MIN_BURST bytes
//   dir           out  WRITING for write slots, READING for read slots
//   port          out  port index inside its direction
//   len           out  burst length: min(level, MAX_BURST), rounded down to even
module slot_eval
    import mem_sched_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int LEVEL_WIDTH = 11,
    parameter int MAX_BURST   = 64,
    parameter int MIN_BURST   = 2,
    parameter int PTR_WIDTH   = 3
) (
    input  logic [PTR_WIDTH-1:0]             slot,
    input  logic [NUM_PORTS*LEVEL_WIDTH-1:0] write_levels,
    input  logic [NUM_PORTS*LEVEL_WIDTH-1:0] read_pending,
    output logic                             eligible,
    output logic                             dir,
    output logic [2:0]                       port,
    output logic [LEVEL_WIDTH-1:0]           len
);

    logic [LEVEL_WIDTH-1:0] level;

    always_comb begin
        level = '0;
        dir   = READING;
        port  = '0;
        for (int g = 0; g < NUM_PORTS; g++) begin
            if (int'(slot) == g) begin
                level = write_levels[g*LEVEL_WIDTH +: LEVEL_WIDTH];
                dir   = WRITING;
                port  = 3'(g);
            end
            if (int'(slot) == g + NUM_PORTS) begin
                level = read_pending[g*LEVEL_WIDTH +: LEVEL_WIDTH];
                dir   = READING;
                port  = 3'(g);
            end
        end
        eligible = (level >= LEVEL_WIDTH'(MIN_BURST));
        len      = LEVEL_WIDTH'(even_clamp_len(32'(level), 32'(MAX_BURST)));
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: picks the next FIFO port for the cellram datapath and the
// burst length to move, walking 2*NUM_PORTS slots round-robin (write ports first,
// then read ports). One grant is outstanding at a time.
//
// Handshake: grant_valid/grant_dir/grant_port/grant_len are registered and held
// stable while grant_valid=1; the grant transfers on a clock edge where both
// grant_valid and grant_ack are 1. grant_ack while grant_valid=0 is ignored.
// burst_done is honoured only in BUSY.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   enable         scheduler runs while high
//   write_levels   bytes waiting per write FIFO (packed LEVEL_WIDTH fields)
//   read_pending   bytes pending per read FIFO (packed LEVEL_WIDTH fields)
//   grant_valid/grant_ack, grant_dir, grant_port, grant_len   grant handshake
//   burst_done     end-of-burst pulse from the datapath
//   sweep_idle     one-cycle pulse after a full sweep found nothing eligible
//   dbg_state      current FSM state (state_t encoding)
//
// Build option: define SCHED_URGENT_EN to let any write port at or above
// URGENT_LEVEL pre-empt the round-robin pointer (lowest port wins).
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int LEVEL_WIDTH  = 11,
    parameter int MAX_BURST    = 64,
    parameter int MIN_BURST    = 2,
    parameter int URGENT_LEVEL = 1536
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [NUM_PORTS*LEVEL_WIDTH-1:0] write_levels,
    input  logic [NUM_PORTS*LEVEL_WIDTH-1:0] read_pending,
    output logic                             grant_valid,
    input  logic                             grant_ack,
    output logic                             grant_dir,
    output logic [2:0]                       grant_port,
    output logic [LEVEL_WIDTH-1:0]           grant_len,
    input  logic                             burst_done,
    output logic                             sweep_idle,
    output logic [1:0]                       dbg_state
);

    localparam int SLOTS     = 2 * NUM_PORTS;
    localparam int PTR_WIDTH = $clog2(SLOTS);

    state_t                 state_q, state_d;
    logic [PTR_WIDTH-1:0]   ptr_q, ptr_d, ptr_inc;
    logic [PTR_WIDTH-1:0]   sweep_q, sweep_d;
    logic                   urgent_q, urgent_d;
    logic                   valid_q, valid_d;
    logic                   dir_q, dir_d;
    logic [2:0]             port_q, port_d;
    logic [LEVEL_WIDTH-1:0] len_q, len_d;
    logic                   idle_q, idle_d;

    logic                   slot_eligible;
    logic                   slot_dir;
    logic [2:0]             slot_port;
    logic [LEVEL_WIDTH-1:0] slot_len;

    logic                   urgent_hit;
    logic [2:0]             urgent_port;
    logic [LEVEL_WIDTH-1:0] urgent_len;

    slot_eval #(
        .NUM_PORTS   (NUM_PORTS),
        .LEVEL_WIDTH (LEVEL_WIDTH),
        .MAX_BURST   (MAX_BURST),
        .MIN_BURST   (MIN_BURST),
        .PTR_WIDTH   (PTR_WIDTH)
    ) u_slot_eval (
        .slot         (ptr_q),
        .write_levels (write_levels),
        .read_pending (read_pending),
        .eligible     (slot_eligible),
        .dir          (slot_dir),
        .port         (slot_port),
        .len          (slot_len)
    );

`ifdef SCHED_URGENT_EN
    // Descending walk so the lowest-numbered urgent port ends up selected.
    always_comb begin
        urgent_hit  = 1'b0;
        urgent_port = '0;
        urgent_len  = '0;
        for (int g = NUM_PORTS - 1; g >= 0; g--) begin
            if (write_levels[g*LEVEL_WIDTH +: LEVEL_WIDTH] >= LEVEL_WIDTH'(URGENT_LEVEL)) begin
                urgent_hit  = 1'b1;
                urgent_port = 3'(g);
                urgent_len  = LEVEL_WIDTH'(even_clamp_len(
                                  32'(write_levels[g*LEVEL_WIDTH +: LEVEL_WIDTH]),
                                  32'(MAX_BURST)));
            end
        end
    end
`else
    localparam int unused_urgent_level = URGENT_LEVEL;
    assign urgent_hit  = 1'b0;
    assign urgent_port = '0;
    assign urgent_len  = '0;
`endif

    assign ptr_inc = (ptr_q == PTR_WIDTH'(SLOTS - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sweep_d  = sweep_q;
        urgent_d = urgent_q;
        valid_d  = valid_q;
        dir_d    = dir_q;
        port_d   = port_q;
        len_d    = len_q;
        idle_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = SCAN;
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (urgent_hit) begin
                    // Urgent grants leave the pointer where it is.
                    valid_d  = 1'b1;
                    dir_d    = WRITING;
                    port_d   = urgent_port;
                    len_d    = urgent_len;
                    sweep_d  = '0;
                    urgent_d = 1'b1;
                    state_d  = GRANT;
                end else if (slot_eligible) begin
                    valid_d  = 1'b1;
                    dir_d    = slot_dir;
                    port_d   = slot_port;
                    len_d    = slot_len;
                    urgent_d = 1'b0;
                    state_d  = GRANT;
                end else begin
                    ptr_d = ptr_inc;
                    if (sweep_q == PTR_WIDTH'(SLOTS - 1)) begin
                        sweep_d = '0;
                        idle_d  = 1'b1;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    valid_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (burst_done) begin
                    // A regular grant left the pointer on its own slot.
                    if (!urgent_q) ptr_d = ptr_inc;
                    sweep_d = '0;
                    state_d = enable ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            sweep_q  <= '0;
            urgent_q <= 1'b0;
            valid_q  <= 1'b0;
            dir_q    <= READING;
            port_q   <= '0;
            len_q    <= '0;
            idle_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sweep_q  <= sweep_d;
            urgent_q <= urgent_d;
            valid_q  <= valid_d;
            dir_q    <= dir_d;
            port_q   <= port_d;
            len_q    <= len_d;
            idle_q   <= idle_d;
        end
    end

    assign grant_valid = valid_q;
    assign grant_dir   = dir_q;
    assign grant_port  = port_q;
    assign grant_len   = len_q;
    assign sweep_idle  = idle_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Decides which FIFO port the cellram datapath services next, and how many bytes it moves.
- Scans 2*NUM_PORTS slots round-robin: write ports 0..N-1 (FIFO to RAM), then read ports 0..N-1 (RAM to FIFO).
- Issues one burst grant at a time over a valid/ack handshake, then waits for burst completion.
- Sits between the FIFO level trackers and the memory transfer engine; replaces the fixed port walk with level-aware, bounded bursts.

Parameters:
- NUM_PORTS, 4, ports per direction; slot count = 2*NUM_PORTS.
- LEVEL_WIDTH, 11, width of each per-port level field (matches FIFO address width).
- MAX_BURST, 64, maximum bytes per grant; must be even.
- MIN_BURST, 2, minimum pending bytes for a slot to be eligible; must be even, >= 2.
- URGENT_LEVEL, 1536, write-FIFO level treated as urgent (optional feature only).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  scheduler runs while high.
- write_levels  in  NUM_PORTS*LEVEL_WIDTH  bytes waiting in each write FIFO; port g at [g*LEVEL_WIDTH +: LEVEL_WIDTH].
- read_pending  in  NUM_PORTS*LEVEL_WIDTH  bytes in RAM not yet delivered to each read FIFO; same packing.
- grant_valid  out  1  grant offered.
- grant_ack  in  1  datapath accepts the grant.
- grant_dir  out  1  0 = READING (RAM to FIFO), 1 = WRITING (FIFO to RAM).
- grant_port  out  3  port index.
- grant_len  out  LEVEL_WIDTH  burst length in bytes; always even.
- burst_done  in  1  single-cycle pulse at the end of the accepted burst.
- sweep_idle  out  1  one-cycle pulse when a full sweep finds no eligible slot.

Behaviour:
- Reset values: grant_valid=0, grant_dir=0, grant_port=0, grant_len=0, sweep_idle=0. The slot pointer, sweep counter and state also reset to 0 / IDLE.
- States: IDLE, SCAN, GRANT, BUSY.
- IDLE: moves to SCAN on the first cycle enable=1.
- SCAN: evaluates one slot per cycle, at the current pointer.
  - Slot s < NUM_PORTS is write port s with level = write_levels[s].
  - Otherwise it is read port s-NUM_PORTS with level = read_pending[s-NUM_PORTS].
  - The slot is eligible when level >= MIN_BURST.
  - If eligible: compute len = min(level, MAX_BURST) with bit 0 cleared. Register grant_dir, grant_port and grant_len, set grant_valid=1 on the next clock, and go to GRANT.
  - If not eligible: pointer = (pointer+1) mod 2*NUM_PORTS and the sweep counter increments.
  - After 2*NUM_PORTS consecutive ineligible slots: pulse sweep_idle for one cycle, clear the counter, keep scanning.
- GRANT: grant_valid and all grant_* outputs are held stable until a cycle with grant_ack=1. On that edge: grant_valid goes to 0 and the state goes to BUSY. An ack while grant_valid=0 is ignored.
- BUSY: waits for burst_done. Then pointer = grant slot + 1 (wrap), the sweep counter clears, and the state goes to SCAN (or IDLE if enable=0).
- burst_done outside BUSY is ignored.
- Latency: eligible slot under the pointer to grant_valid high is 1 clock. A new grant can start scanning the cycle after burst_done.
- enable deasserted:
  - In SCAN: go to IDLE next cycle.
  - In GRANT: the grant stays up until acked (no retraction), then BUSY, then IDLE.
  - In BUSY: the burst completes first.
- Boundary cases:
  - Odd levels round down (level 5 gives len 4).
  - A level of exactly MIN_BURST is eligible.
  - Levels above MAX_BURST clamp to MAX_BURST.
  - Pointer wraps from 2*NUM_PORTS-1 to 0.
- Levels are sampled only in SCAN; changes during GRANT/BUSY have no effect on the outstanding grant.
- Reset mid-operation (any state) returns all outputs to their reset values on the next clock; no burst_done is awaited.

Optional Feature:
- Macro SCHED_URGENT_EN.
- Defined: in SCAN, if any write port has level >= URGENT_LEVEL, the lowest-numbered such port is granted immediately, regardless of the pointer.
  - Its len is still clamped to MAX_BURST and made even.
  - The pointer is not moved by an urgent grant.
  - The sweep counter clears.
- Undefined: pure round-robin; URGENT_LEVEL is unused.

Decomposition:
- Shared package mem_sched_pkg holds:
  - the direction constants READING=1'b0 and WRITING=1'b1;
  - the state encoding typedef;
  - a function computing even clamped length.
- Natural sub-module slot_eval: combinational slot select, eligibility and len computation, instantiated once.
- The FSM, pointer and registers stay in the top module.

Test Plan:
- After reset, write_levels[0]=10: grant_valid rises 1 cycle after SCAN evaluates slot 0, with grant_dir=1, grant_port=0, grant_len=10. Hold grant_ack low for 5 cycles; outputs stay stable.
- read_pending[2]=200, all others 0: grant dir=0, port=2, len=64. After burst_done, scanning resumes at slot 7.
- write_levels[1]=5 → len=4; level 1 → never granted. All levels 0 → sweep_idle pulses every 8 cycles.
- All slots at level 8: grants appear in order w0,w1,w2,w3,r0,r1,r2,r3,w0, each after ack plus burst_done.
- Drop enable during BUSY: after burst_done the state is IDLE and no new grant_valid appears. Assert reset while in GRANT: grant_valid=0 on the next clock.
- With SCHED_URGENT_EN: pointer at slot 5, write_levels[3]=1600 → immediate grant w3, len=64. The next regular grant comes from slot 5.
